// File: rtl/addsub_pkg.sv
// Shared encodings and elaboration helpers for the pipelined add/subtract unit.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Each stage must own an equal, non-empty slice of the operand.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead adder slice; zero latency, no flow control.
// Exposes the carry into its MSB so the last slice can form signed overflow.
module cla_segment #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);

    logic [SEG-1:0] gen;
    logic [SEG-1:0] prop;
    logic [SEG-1:0] carry;
    logic           grp_g;
    logic           grp_p;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every internal carry is a flat sum-of-products over the lower bits.
    always_comb begin
        logic acc;
        logic pp;
        carry    = '0;
        carry[0] = cin;
        for (int i = 1; i < SEG; i++) begin
            acc = gen[i-1];
            pp  = prop[i-1];
            for (int j = i - 2; j >= 0; j--) begin
                acc = acc | (pp & gen[j]);
                pp  = pp & prop[j];
            end
            carry[i] = acc | (pp & cin);
        end
    end

    always_comb begin
        logic pp;
        grp_g = gen[SEG-1];
        pp    = prop[SEG-1];
        for (int j = SEG - 2; j >= 0; j--) begin
            grp_g = grp_g | (pp & gen[j]);
            pp    = pp & prop[j];
        end
        grp_p = pp;
    end

    assign sum      = prop ^ carry;
    assign cout     = grp_g | (grp_p & cin);
    assign c_msb_in = carry[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Skewed add/subtract pipeline: one carry-lookahead slice per stage, registered carry between.
// Latency STAGES edges from acceptance; a stalled output freezes every stage (in_ready = ~stall).
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic stall;
    logic en;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO  = k * SEG;
        localparam int REM = WIDTH - LO;

        // Operand bits not yet consumed, carry and result so far entering this stage.
        logic [REM-1:0]    sa;
        logic [REM-1:0]    sb;
        logic              sc;
        logic              sv;
        logic [TAG_W-1:0]  stag;
        logic [SEG-1:0]    sum;
        logic              cout;
        logic              c_msb;
        logic [LO+SEG-1:0] res_d;

        logic              vld_q;
        logic              c_q;
        logic [TAG_W-1:0]  tag_q;
        logic [LO+SEG-1:0] res_q;

        if (k == 0) begin : g_first
            // SUB folds into ADD: A + ~B + ~borrow.
            assign sa    = in_a;
            assign sb    = (in_op == OP_SUB) ? ~in_b : in_b;
            assign sc    = (in_op == OP_SUB) ? ~in_cin : in_cin;
            assign sv    = in_valid;
            assign stag  = in_tag;
            assign res_d = sum;
        end else begin : g_next
            assign sa    = g_st[k-1].g_fwd.a_q;
            assign sb    = g_st[k-1].g_fwd.b_q;
            assign sc    = g_st[k-1].c_q;
            assign sv    = g_st[k-1].vld_q;
            assign stag  = g_st[k-1].tag_q;
            assign res_d = {sum, g_st[k-1].res_q};
        end

        cla_segment #(
            .SEG(SEG)
        ) u_cla (
            .a        (sa[SEG-1:0]),
            .b        (sb[SEG-1:0]),
            .cin      (sc),
            .sum      (sum),
            .cout     (cout),
            .c_msb_in (c_msb)
        );

        // Valid bits advance on every enabled edge so bubbles keep their slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                tag_q <= '0;
                res_q <= '0;
            end else if (en) begin
                vld_q <= sv;
                if (sv) begin
                    c_q   <= cout;
                    tag_q <= stag;
                    res_q <= res_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] b_q;
            logic               c_msb_unused;

            assign c_msb_unused = c_msb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && sv) begin
                    a_q <= sa[REM-1:SEG];
                    b_q <= sb[REM-1:SEG];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en && sv) begin
                    ovf_q  <= c_msb ^ cout;
                    zero_q <= ~|res_d;
                end
            end
        end
    end

    assign out_valid  = g_st[STAGES-1].vld_q;
    assign out_result = g_st[STAGES-1].res_q;
    assign out_cout   = g_st[STAGES-1].c_q;
    assign out_tag    = g_st[STAGES-1].tag_q;
    assign out_ovf    = g_st[STAGES-1].g_last.ovf_q;
    assign out_zero   = g_st[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub at 32/2 and 16/4; directed vectors plus a modelled random burst.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 32-bit, 2-stage instance
    logic        iv32, ird32, icin32, iop32, ov32, ordy32, oc32, oo32, oz32;
    logic [31:0] ia32, ib32, or32;
    logic [4:0]  itag32, otag32;

    // 16-bit, 4-stage instance
    logic        iv16, ird16, icin16, iop16, ov16, ordy16, oc16, oo16, oz16;
    logic [15:0] ia16, ib16, or16;
    logic [4:0]  itag16, otag16;

    pipelined_addsub #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ird32), .in_a(ia32), .in_b(ib32),
        .in_cin(icin32), .in_op(iop32), .in_tag(itag32),
        .out_valid(ov32), .out_ready(ordy32), .out_result(or32),
        .out_cout(oc32), .out_ovf(oo32), .out_zero(oz32), .out_tag(otag32)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(4), .TAG_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ird16), .in_a(ia16), .in_b(ib16),
        .in_cin(icin16), .in_op(iop16), .in_tag(itag16),
        .out_valid(ov16), .out_ready(ordy16), .out_result(or16),
        .out_cout(oc16), .out_ovf(oo16), .out_zero(oz16), .out_tag(otag16)
    );

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rnd_on = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    exp_t        e32, e16;
    bit          hold32 = 0, hold16 = 0;
    logic [31:0] h_res32;
    logic [15:0] h_res16;
    logic        h_c32, h_o32, h_z32, h_c16, h_o16, h_z16;
    logic [4:0]  h_tag32, h_tag16;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold32 = 0;
        end else begin
            check("in_ready32", 32'(ird32), 32'(!(ov32 && !ordy32)));
            if (hold32) begin
                check("hold_vld32", 32'(ov32), 32'd1);
                check("hold_res32", or32, h_res32);
                check("hold_flags32", {29'd0, oc32, oo32, oz32}, {29'd0, h_c32, h_o32, h_z32});
                check("hold_tag32", 32'(otag32), 32'(h_tag32));
            end
            if (ov32 && ordy32) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected32: result %h tag %0d with empty scoreboard", or32, otag32);
                end else begin
                    e32 = q32.pop_front();
                    check("res32", or32, e32.res);
                    check("cout32", 32'(oc32), 32'(e32.cout));
                    check("ovf32", 32'(oo32), 32'(e32.ovf));
                    check("zero32", 32'(oz32), 32'(e32.res == 32'd0));
                    check("tag32", 32'(otag32), 32'(e32.tag));
                    if (e32.lat) check("latency32", 32'(cyc - e32.acc), 32'd1);
                end
            end
            hold32  = ov32 && !ordy32;
            h_res32 = or32; h_c32 = oc32; h_o32 = oo32; h_z32 = oz32; h_tag32 = otag32;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold16 = 0;
        end else begin
            check("in_ready16", 32'(ird16), 32'(!(ov16 && !ordy16)));
            if (hold16) begin
                check("hold_res16", 32'(or16), 32'(h_res16));
                check("hold_flags16", {28'd0, ov16, oc16, oo16, oz16}, {28'd0, 1'b1, h_c16, h_o16, h_z16});
                check("hold_tag16", 32'(otag16), 32'(h_tag16));
            end
            if (ov16 && ordy16) begin
                if (q16.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected16: result %h tag %0d with empty scoreboard", or16, otag16);
                end else begin
                    e16 = q16.pop_front();
                    check("res16", 32'(or16), e16.res);
                    check("cout16", 32'(oc16), 32'(e16.cout));
                    check("ovf16", 32'(oo16), 32'(e16.ovf));
                    check("zero16", 32'(oz16), 32'(e16.res == 32'd0));
                    check("tag16", 32'(otag16), 32'(e16.tag));
                    if (e16.lat) check("latency16", 32'(cyc - e16.acc), 32'd3);
                end
            end
            hold16  = ov16 && !ordy16;
            h_res16 = or16; h_c16 = oc16; h_o16 = oo16; h_z16 = oz16; h_tag16 = otag16;
        end
    end

    // ---------------- drivers (called at posedge+1, return at posedge+1) ----------------
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic op,
                          input logic [4:0] tag, input logic [31:0] er, input logic ec, input logic eo,
                          input bit lat);
        bit done = 0;
        int n = 0;
        iv32 = 1'b1; ia32 = a; ib32 = b; icin32 = cin; iop32 = op; itag32 = tag;
        while (!done && n < 100) begin
            @(negedge clk);
            if (ird32) begin
                q32.push_back('{er, ec, eo, tag, cyc + 1, lat});
                done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        iv32 = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send32_timeout: in_ready stayed 0, expected acceptance within 100 cycles");
        end
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op,
                          input logic [4:0] tag, input logic [15:0] er, input logic ec, input logic eo,
                          input bit lat);
        bit done = 0;
        int n = 0;
        iv16 = 1'b1; ia16 = a; ib16 = b; icin16 = cin; iop16 = op; itag16 = tag;
        while (!done && n < 100) begin
            @(negedge clk);
            if (ird16) begin
                q16.push_back('{32'(er), ec, eo, tag, cyc + 1, lat});
                done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        iv16 = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send16_timeout: in_ready stayed 0, expected acceptance within 100 cycles");
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (q32.size() != 0 || q16.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d/%0d results outstanding, expected 0", q32.size(), q16.size());
        end
    endtask

    // Independent 16-bit reference: widened sum with sign-rule overflow.
    task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op,
                           output logic [15:0] r, output logic c, output logic o);
        logic [16:0] s;
        logic [15:0] be;
        logic        ce;
        be = op ? ~b : b;
        ce = op ? ~cin : cin;
        s  = {1'b0, a} + {1'b0, be} + {16'd0, ce};
        r  = s[15:0];
        c  = s[16];
        o  = (a[15] == be[15]) && (s[15] != a[15]);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_on) ordy16 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ra, rb, rr;
        logic        rc, rop, rco, roo;

        rst_n = 1'b0;
        iv32 = 0; ia32 = '0; ib32 = '0; icin32 = 0; iop32 = 0; itag32 = '0; ordy32 = 1'b1;
        iv16 = 0; ia16 = '0; ib16 = '0; icin16 = 0; iop16 = 0; itag16 = '0; ordy16 = 1'b1;

        #12;
        check("rst_vld32", 32'(ov32), 32'd0);
        check("rst_out32", {or32 | {26'd0, oc32, oo32, oz32, otag32[2:0]}}, 32'd0);
        check("rst_tag32", 32'(otag32), 32'd0);
        check("rst_rdy32", 32'(ird32), 32'd1);
        check("rst_vld16", 32'(ov16), 32'd0);
        check("rst_out16", {13'd0, oc16, oo16, oz16, or16}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry ripples through both slices, overflow and the segment boundary.
        send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 5'd3,  32'h0000_0000, 1'b1, 1'b0, 1);
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 5'd4,  32'h8000_0000, 1'b0, 1'b1, 0);
        send32(32'h0000_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 5'd5,  32'h0001_0000, 1'b0, 1'b0, 0);
        send32(32'h0000_0001, 32'h0000_0002, 1'b1, OP_ADD, 5'd6,  32'h0000_0004, 1'b0, 1'b0, 0);
        // Subtraction: borrow, signed overflow, borrow-in.
        send32(32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB, 5'd7,  32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        send32(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 5'd8,  32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        send32(32'h0000_0009, 32'h0000_0004, 1'b1, OP_SUB, 5'd9,  32'h0000_0004, 1'b1, 1'b0, 0);
        drain(50);

        // Eight back-to-back ops with the sink stalled for three cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send32(32'(i) << 28, 32'h0000_FFFF, 1'b1, OP_ADD, 5'(i),
                           (32'(i) << 28) | 32'h0001_0000, 1'b0, 1'b0, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 ordy32 = 1'b0;
                repeat (3) @(posedge clk);
                #1 ordy32 = 1'b1;
            end
        join
        drain(50);

        // Reset with two operations in flight; they must vanish.
        iv32 = 1'b1; ia32 = 32'd1; ib32 = 32'd1; icin32 = 0; iop32 = OP_ADD; itag32 = 5'd9;
        @(posedge clk); #1;
        ia32 = 32'd2; itag32 = 5'd10;
        @(posedge clk); #1;
        iv32 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_vld32", 32'(ov32), 32'd0);
        check("midrst_res32", or32, 32'd0);
        check("midrst_flags32", {29'd0, oc32, oo32, oz32}, 32'd0);
        check("midrst_tag32", 32'(otag32), 32'd0);
        check("midrst_rdy32", 32'(ird32), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_vld32", 32'(ov32), 32'd0);
        end
        @(posedge clk); #1;
        send32(32'h1234_5678, 32'h1111_1111, 1'b0, OP_ADD, 5'd17, 32'h2345_6789, 1'b0, 1'b0, 1);
        drain(50);

        // 16-bit, 4-stage instance.
        send16(16'h0FFF, 16'h0001, 1'b0, OP_ADD, 5'd1, 16'h1000, 1'b0, 1'b0, 1);
        drain(50);
        send16(16'hFFFF, 16'h0000, 1'b1, OP_ADD, 5'd2, 16'h0000, 1'b1, 1'b0, 0);
        send16(16'h8000, 16'h0001, 1'b0, OP_SUB, 5'd3, 16'h7FFF, 1'b1, 1'b1, 0);
        rnd_on = 1;
        for (int i = 0; i < 24; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            rop = 1'($urandom);
            if (i % 6 == 0) rb = ra;
            model16(ra, rb, rc, rop, rr, rco, roo);
            send16(ra, rb, rc, rop, 5'(i), rr, rco, roo, 0);
        end
        rnd_on = 0;
        ordy16 = 1'b1;
        drain(200);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit for the CPU datapath, the successor to the fixed-width combinational carry-lookahead adder.
- Splits a WIDTH-bit operation into STAGES equal carry-lookahead segments, one per pipeline stage, with a registered carry between stages.
- Uses a valid/ready handshake on both sides and carries a tag (e.g. destination register id) alongside the data.
- Produces result, carry-out, signed overflow and zero flags for ALU/branch use.

Parameters:
WIDTH, 32, operand/result width; must be divisible by STAGES
STAGES, 2, pipeline stages = carry segments; range 1..WIDTH; SEG = WIDTH/STAGES
TAG_W, 5, width of the sideband tag passed through unchanged

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands valid
in_ready  output  1  unit accepts operands this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in (ADD) / borrow-in (SUB)
in_op  input  1  0 = ADD, 1 = SUB (encoding in addsub_pkg)
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  sum/difference
out_cout  output  1  raw carry-out of MSB; for SUB, 1 = no borrow
out_ovf  output  1  signed overflow
out_zero  output  1  out_result == 0
out_tag  output  TAG_W  tag of this result

Behaviour:
Clock and reset:
- Single clock. Reset is asynchronous and active-low, on rst_n.
- While rst_n = 0, every stage valid bit and every output register is 0, so out_valid, out_result, out_cout, out_ovf, out_zero and out_tag are all 0.

Arithmetic:
- ADD: A + B + cin.
- SUB: A + ~B + ~cin, i.e. A - B - cin.
- All arithmetic is modulo 2^WIDTH.

Pipeline:
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] from the carry registered by stage k-1; stage 0 uses the effective carry-in (cin, or ~cin for SUB).
- Not-yet-processed operand slices and already-computed result slices shift forward with each entry (skewed pipeline).
- The final stage registers out_result, out_cout and the flags:
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = NOR of all result bits, formed in the final stage.
- Latency: a transfer accepted at edge N presents out_valid = 1 after edge N+STAGES-1, provided there is no stall. STAGES = 1 gives a registered output in the cycle after acceptance.
- Throughput: one operation per cycle.

Handshake:
- stall = out_valid & ~out_ready. The whole pipeline freezes on stall (global enable).
- in_ready = ~stall. A transfer occurs when in_valid & in_ready.
- Stage valid bits propagate without the enable gating bubbles; bubbles are not collapsed.
- Outputs are held stable while out_valid = 1 and out_ready = 0.
- Results leave in acceptance order. None is dropped or duplicated.
- Simultaneous input acceptance and output retirement in the same cycle is legal.
- in_* are ignored when in_valid = 0. Contents of invalid stages are don't-care, but out_* data must read 0 after reset until the first valid result.

Reset mid-operation:
- Asserting rst_n discards all in-flight operations immediately.
- After rst_n deasserts, no stale result appears; in_ready = 1 on the first cycle.

Decomposition:
Package addsub_pkg contains:
- OP_ADD = 1'b0, OP_SUB = 1'b1.
- A function computing SEG from WIDTH and STAGES.
- Elaboration check: WIDTH % STAGES == 0, else $error.

Sub-module cla_segment #(SEG):
- Combinational SEG-bit carry-lookahead adder with group generate/propagate.
- Ports: a, b, cin, sum, cout, c_msb_in (carry into its MSB, for overflow).
- Instantiated STAGES times in a generate loop.

Top level holds the pipeline registers, valid bits and stall logic.

Test Plan:
1. WIDTH=32, STAGES=2, ADD 0xFFFFFFFF + 0x00000001, cin=0 -> two cycles later: result 0x00000000, cout=1, ovf=0, zero=1, tag echoed.
2. ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, cout=0, ovf=1, zero=0. Then ADD 0x0000FFFF + 0x00000001 -> 0x00010000, checking the carry across the segment boundary.
3. SUB 5 - 7, cin=0 -> 0xFFFFFFFE, cout=0 (borrow), ovf=0. SUB 0x80000000 - 1 -> 0x7FFFFFFF, cout=1, ovf=1. SUB 9 - 4, cin=1 -> 0x00000004.
4. Stream 8 ops with tags 0..7, holding out_ready=0 for cycles 3-5:
   - in_ready=0 exactly while stalled;
   - outputs stable during the stall;
   - all 8 results arrive in tag order, none lost or duplicated.
5. Pulse rst_n low with 2 ops in flight -> out_valid=0 asynchronously, all outputs 0. After release, no result appears until new input arrives, and the next op returns its correct result with latency STAGES.
6. Re-elaborate with WIDTH=16, STAGES=4:
   - ADD 0x0FFF + 0x0001 -> 0x1000 after 4 cycles;
   - ADD 0xFFFF + 0x0000, cin=1 -> 0x0000, cout=1, zero=1;
   - random back-to-back ops match a reference model.
